// File: rtl/ieee754_addsub_seq_if.sv
// Start/done request bus of the sequential binary32 add/subtract unit.
// Master drives the request and operands; slave returns busy, done and the result.
interface ieee754_addsub_seq_if;
  logic        start;
  logic        op;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [31:0] out;
  logic        busy;
  logic        done;

  modport master (output start, op, input1, input2, input out, busy, done);
  modport slave  (input start, op, input1, input2, output out, busy, done);
endinterface

// File: rtl/ieee754_addsub_seq.sv
// Sequential binary32 add/subtract, round-to-nearest-even, flush-to-zero; done 5 cycles after start.
// No backpressure: start is taken only in IDLE and ignored while an operation is in flight.
module ieee754_addsub_seq (
  input  logic                        clk,
  input  logic                        rst,
  ieee754_addsub_seq_if.slave         io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND
  } state_t;

  state_t state_q;

  // Captured operands; opb already carries the effective sign for subtract.
  logic [31:0] opa_q, opb_q;

  logic        s1_q, s2_q, s1_d, s2_d;
  logic [7:0]  e1_q, e2_q, e1_d, e2_d;
  logic [23:0] m1_q, m2_q, m1_d, m2_d;
  logic        z1_q, z2_q, z1_d, z2_d;
  logic        inf1_q, inf2_q, inf1_d, inf2_d;
  logic        nan_q, nan_d;

  logic        sgn_q, sgn_d;
  logic        effsub_q, effsub_d;
  logic [7:0]  ea_q, ea_d;
  logic [26:0] ma_q, ma_d;
  logic [26:0] mb_q, mb_d;

  logic [27:0] sum_q, sum_d;

  logic [9:0]  en_q, en_d;
  logic [26:0] mn_q, mn_d;
  logic        zres_q, zres_d;

  logic [31:0] out_q, out_d;
  logic        busy_q;
  logic        done_q;

  // Unpack and classify.
  always_comb begin
    s1_d   = opa_q[31];
    s2_d   = opb_q[31];
    e1_d   = opa_q[30:23];
    e2_d   = opb_q[30:23];
    z1_d   = (e1_d == 8'd0);
    z2_d   = (e2_d == 8'd0);
    m1_d   = z1_d ? 24'd0 : {1'b1, opa_q[22:0]};
    m2_d   = z2_d ? 24'd0 : {1'b1, opb_q[22:0]};
    inf1_d = (e1_d == 8'hFF) && (opa_q[22:0] == 23'd0);
    inf2_d = (e2_d == 8'hFF) && (opb_q[22:0] == 23'd0);
    nan_d  = ((e1_d == 8'hFF) && (opa_q[22:0] != 23'd0)) ||
             ((e2_d == 8'hFF) && (opb_q[22:0] != 23'd0));
  end

  logic        swap;
  logic [7:0]  small_e, diff;
  logic [23:0] small_m;
  logic [49:0] wide;

  // Align: A is the larger magnitude, B shifted right with guard/round/sticky.
  always_comb begin
    swap     = (e2_q > e1_q) || ((e2_q == e1_q) && (m2_q > m1_q));
    ea_d     = swap ? e2_q : e1_q;
    ma_d     = {(swap ? m2_q : m1_q), 3'b000};
    sgn_d    = swap ? s2_q : s1_q;
    small_e  = swap ? e1_q : e2_q;
    small_m  = swap ? m1_q : m2_q;
    effsub_d = s1_q ^ s2_q;
    diff     = ea_d - small_e;
    wide     = {small_m, 26'd0} >> diff;
    if (diff >= 8'd26) begin
      mb_d = {26'd0, |small_m};
    end else begin
      mb_d = {wide[49:24], |wide[23:0]};
    end
  end

  always_comb begin
    if (effsub_q) begin
      sum_d = {1'b0, ma_q} - {1'b0, mb_q};
    end else begin
      sum_d = {1'b0, ma_q} + {1'b0, mb_q};
    end
  end

  logic [4:0] lzc;
  logic       found;

  // Normalise: priority encoder gives the left-shift amount when there is no carry.
  always_comb begin
    lzc   = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum_q[i]) begin
        found = 1'b1;
        lzc   = 5'(26 - i);
      end
    end
    zres_d = (sum_q == 28'd0);
    if (sum_q[27]) begin
      mn_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
      en_d = {2'b00, ea_q} + 10'd1;
    end else begin
      mn_d = sum_q[26:0] << lzc;
      en_d = {2'b00, ea_q} - {5'd0, lzc};
    end
  end

  logic        rnd_up;
  logic [24:0] sig_r;
  logic [9:0]  er;
  logic [22:0] frac_r;

  // Round to nearest even; en/er are two's complement so bit 9 flags underflow.
  always_comb begin
    rnd_up = mn_q[2] & (mn_q[1] | mn_q[0] | mn_q[3]);
    sig_r  = {1'b0, mn_q[26:3]} + {24'd0, rnd_up};
    er     = sig_r[24] ? en_q + 10'd1 : en_q;
    frac_r = sig_r[24] ? sig_r[23:1] : sig_r[22:0];
    if (nan_q || (inf1_q && inf2_q && (s1_q != s2_q))) begin
      out_d = 32'h7FC00000;
    end else if (inf1_q) begin
      out_d = {s1_q, 8'hFF, 23'd0};
    end else if (inf2_q) begin
      out_d = {s2_q, 8'hFF, 23'd0};
    end else if (zres_q) begin
      out_d = {z1_q & z2_q & s1_q & s2_q, 31'd0};
    end else if (er[9] || (er == 10'd0)) begin
      out_d = {sgn_q, 31'd0};
    end else if (er >= 10'd255) begin
      out_d = {sgn_q, 8'hFF, 23'd0};
    end else begin
      out_d = {sgn_q, er[7:0], frac_r};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      e1_q     <= 8'd0;
      e2_q     <= 8'd0;
      m1_q     <= 24'd0;
      m2_q     <= 24'd0;
      z1_q     <= 1'b0;
      z2_q     <= 1'b0;
      inf1_q   <= 1'b0;
      inf2_q   <= 1'b0;
      nan_q    <= 1'b0;
      sgn_q    <= 1'b0;
      effsub_q <= 1'b0;
      ea_q     <= 8'd0;
      ma_q     <= 27'd0;
      mb_q     <= 27'd0;
      sum_q    <= 28'd0;
      en_q     <= 10'd0;
      mn_q     <= 27'd0;
      zres_q   <= 1'b0;
      out_q    <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (io.start) begin
            opa_q   <= io.input1;
            opb_q   <= {io.input2[31] ^ io.op, io.input2[30:0]};
            state_q <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          s1_q    <= s1_d;
          s2_q    <= s2_d;
          e1_q    <= e1_d;
          e2_q    <= e2_d;
          m1_q    <= m1_d;
          m2_q    <= m2_d;
          z1_q    <= z1_d;
          z2_q    <= z2_d;
          inf1_q  <= inf1_d;
          inf2_q  <= inf2_d;
          nan_q   <= nan_d;
          busy_q  <= 1'b1;
          state_q <= S_ALIGN;
        end
        S_ALIGN: begin
          sgn_q    <= sgn_d;
          effsub_q <= effsub_d;
          ea_q     <= ea_d;
          ma_q     <= ma_d;
          mb_q     <= mb_d;
          state_q  <= S_ADD;
        end
        S_ADD: begin
          sum_q   <= sum_d;
          state_q <= S_NORM;
        end
        S_NORM: begin
          en_q    <= en_d;
          mn_q    <= mn_d;
          zres_q  <= zres_d;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          out_q   <= out_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign io.out  = out_q;
  assign io.busy = busy_q;
  assign io.done = done_q;

endmodule
